// File: rtl/rv32im_lsu_seq.sv
// Sequential load/store unit: one access in flight, lane-aligned stores,
// extended loads, misalignment/illegal-opcode detection and memory timeout.
// Opcode encoding: loads {LB=0,LH=1,LW=2,LBU=4,LHU=5}, stores {SB=8,SH=9,SW=10}.
module rv32im_lsu_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OPC_WIDTH  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [OPC_WIDTH-1:0]  lsu_opcode_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  localparam logic [OPC_WIDTH-1:0] OPC_LB  = OPC_WIDTH'(0);
  localparam logic [OPC_WIDTH-1:0] OPC_LH  = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OPC_LW  = OPC_WIDTH'(2);
  localparam logic [OPC_WIDTH-1:0] OPC_LBU = OPC_WIDTH'(4);
  localparam logic [OPC_WIDTH-1:0] OPC_LHU = OPC_WIDTH'(5);
  localparam logic [OPC_WIDTH-1:0] OPC_SB  = OPC_WIDTH'(8);
  localparam logic [OPC_WIDTH-1:0] OPC_SH  = OPC_WIDTH'(9);
  localparam logic [OPC_WIDTH-1:0] OPC_SW  = OPC_WIDTH'(10);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_GNT, S_WAIT_RD, S_RESP} state_t;

  // Access size: 0=byte, 1=half, 2=word, 3=illegal opcode.
  function automatic logic [1:0] opc_size(input logic [OPC_WIDTH-1:0] o);
    case (o)
      OPC_LB, OPC_LBU, OPC_SB: opc_size = 2'd0;
      OPC_LH, OPC_LHU, OPC_SH: opc_size = 2'd1;
      OPC_LW, OPC_SW:          opc_size = 2'd2;
      default:                 opc_size = 2'd3;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [OPC_WIDTH-1:0]    opc_q, opc_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic       accept, req_bad, timed_out, is_store;
  logic [1:0] in_size, size_q, off;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  assign accept    = req_valid_i && (state_q == S_IDLE);
  assign in_size   = opc_size(lsu_opcode_i);
  assign req_bad   = (in_size == 2'd3) ||
                     ((in_size == 2'd1) && addr_i[0]) ||
                     ((in_size == 2'd2) && (addr_i[1:0] != 2'b00));
  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign size_q    = opc_size(opc_q);
  assign is_store  = (opc_q == OPC_SB) || (opc_q == OPC_SH) || (opc_q == OPC_SW);
  assign off       = addr_q[1:0];
  assign ld_byte   = mem_rdata_i[8*off +: 8];
  assign ld_half   = mem_rdata_i[16*off[1] +: 16];

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: gnt/rvalid win over a timeout landing on the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = req_bad ? S_RESP : S_WAIT_GNT;
      S_WAIT_GNT: if (mem_gnt_i) state_d = is_store ? S_RESP : S_WAIT_RD;
                  else if (timed_out) state_d = S_RESP;
      S_WAIT_RD:  if (mem_rvalid_i || timed_out) state_d = S_RESP;
      S_RESP:     if (rsp_ready_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Request latch, load extraction, error capture and wait-cycle counter
  always_comb begin
    opc_d   = opc_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (accept) begin
        opc_d   = lsu_opcode_i;
        addr_d  = addr_i;
        wdata_d = wdata_i;
        rdata_d = '0;
        err_d   = req_bad;
      end
      S_WAIT_GNT: if (!mem_gnt_i && timed_out) err_d = 1'b1;
      S_WAIT_RD: begin
        if (mem_rvalid_i) begin
          case (opc_q)
            OPC_LB:  rdata_d = {{24{ld_byte[7]}}, ld_byte};
            OPC_LBU: rdata_d = {24'b0, ld_byte};
            OPC_LH:  rdata_d = {{16{ld_half[15]}}, ld_half};
            OPC_LHU: rdata_d = {16'b0, ld_half};
            default: rdata_d = mem_rdata_i;
          endcase
        end else if (timed_out) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decoded from state; memory side driven only while requesting
  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    mem_req_o   = (state_q == S_WAIT_GNT);
    rsp_valid_o = (state_q == S_RESP);
    rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    rsp_err_o   = rsp_valid_o && err_q;
    mem_we_o    = mem_req_o && is_store;
    mem_addr_o  = mem_req_o ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      case (size_q)
        2'd0:    mem_be_o = 4'b0001 << off;
        2'd1:    mem_be_o = 4'b0011 << off;
        default: mem_be_o = 4'b1111;
      endcase
      if (is_store) begin
        case (size_q)
          2'd0:    mem_wdata_o = {4{wdata_q[7:0]}};
          2'd1:    mem_wdata_o = {2{wdata_q[15:0]}};
          default: mem_wdata_o = wdata_q;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rv32im_lsu_seq.sv
// Directed bench for rv32im_lsu_seq: vector table plus timeout/hold/reset sequences.
module tb_rv32im_lsu_seq;
  localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd4, LHU = 4'd5;
  localparam logic [3:0] SB = 4'd8, SH = 4'd9, SW = 4'd10;

  logic        clk = 0;
  logic        rst = 1;
  logic        req_valid = 0, req_ready;
  logic [3:0]  opc = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_gnt = 0, mem_we, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  rv32im_lsu_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .OPC_WIDTH(4), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .lsu_opcode_i(opc), .addr_i(addr), .wdata_i(wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  opc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_mem;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h", name, act, exp);
    end
  endtask

  // Issue one request at the current negedge; zero-wait memory.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    opc = v.opc; addr = v.addr; wdata = v.wdata; req_valid = 1;
    #1 chk({t, ".req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk); req_valid = 0;
    #1;
    chk({t, ".mem_req"}, 32'(mem_req), 32'(v.exp_mem));
    if (v.exp_mem) begin
      chk({t, ".mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
      chk({t, ".mem_be"}, 32'(mem_be), 32'(v.exp_be));
      chk({t, ".mem_we"}, 32'(mem_we), 32'(v.exp_we));
      chk({t, ".mem_wdata"}, mem_wdata, v.exp_wdata);
      mem_gnt = 1;
      @(negedge clk); mem_gnt = 0;
      if (!v.exp_we) begin
        #1 chk({t, ".req_in_rd"}, 32'(mem_req), 32'd0);
        mem_rvalid = 1; mem_rdata = v.rdata;
        @(negedge clk); mem_rvalid = 0; mem_rdata = 0;
      end
      #1;
    end
    chk({t, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({t, ".rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({t, ".rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    #1 chk({t, ".idle_after"}, 32'({rsp_valid, req_ready}), 32'b01);
  endtask

  initial begin
    int n;
    logic [31:0] held;
    //        opc  addr          wdata         rdata         mem be     we wdata         rdata         err
    vecs[0]  = '{LW,  32'h100, 32'h0,        32'hDEADBEEF, 1, 4'b1111, 0, 32'h0,        32'hDEADBEEF, 0};
    vecs[1]  = '{LB,  32'h103, 32'h0,        32'h80FF0000, 1, 4'b1000, 0, 32'h0,        32'hFFFFFF80, 0};
    vecs[2]  = '{LBU, 32'h103, 32'h0,        32'h80FF0000, 1, 4'b1000, 0, 32'h0,        32'h00000080, 0};
    vecs[3]  = '{LH,  32'h102, 32'h0,        32'h80FF0000, 1, 4'b1100, 0, 32'h0,        32'hFFFF80FF, 0};
    vecs[4]  = '{LHU, 32'h100, 32'h0,        32'h1234F00D, 1, 4'b0011, 0, 32'h0,        32'h0000F00D, 0};
    vecs[5]  = '{LB,  32'h101, 32'h0,        32'h00007F00, 1, 4'b0010, 0, 32'h0,        32'h0000007F, 0};
    vecs[6]  = '{SH,  32'h102, 32'h1234ABCD, 32'h0,        1, 4'b1100, 1, 32'hABCDABCD, 32'h0,        0};
    vecs[7]  = '{SB,  32'h101, 32'h000000A5, 32'h0,        1, 4'b0010, 1, 32'hA5A5A5A5, 32'h0,        0};
    vecs[8]  = '{SW,  32'h200, 32'hCAFEF00D, 32'h0,        1, 4'b1111, 1, 32'hCAFEF00D, 32'h0,        0};
    vecs[9]  = '{LW,  32'h101, 32'h0,        32'h0,        0, 4'b0000, 0, 32'h0,        32'h0,        1};
    vecs[10] = '{SH,  32'h103, 32'h5555,     32'h0,        0, 4'b0000, 0, 32'h0,        32'h0,        1};
    vecs[11] = '{4'hF,32'h100, 32'h0,        32'h0,        0, 4'b0000, 0, 32'h0,        32'h0,        1};
    vecs[12] = '{LH,  32'h105, 32'h0,        32'h0,        0, 4'b0000, 0, 32'h0,        32'h0,        1};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.outs", {rsp_valid, rsp_err, mem_req, mem_we, mem_be}, 32'd0);
    chk("rst.buses", rsp_rdata | mem_addr | mem_wdata, 32'd0);
    @(negedge clk); rst = 0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Grant timeout: request held 4 cycles then error response
    @(negedge clk);
    opc = LW; addr = 32'h300; req_valid = 1;
    @(negedge clk); req_valid = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!mem_req) break;
      n++;
      @(negedge clk);
    end
    chk("to_gnt.req_cycles", 32'(n), 32'd4);
    chk("to_gnt.rsp", {rsp_valid, rsp_err}, 32'b11);
    chk("to_gnt.rdata", rsp_rdata, 32'd0);
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    #1 chk("to_gnt.idle", 32'({req_ready, mem_req}), 32'b10);

    // Read-data timeout: granted but no rvalid for 4 cycles
    @(negedge clk);
    opc = LW; addr = 32'h304; req_valid = 1;
    @(negedge clk); req_valid = 0; mem_gnt = 1;
    @(negedge clk); mem_gnt = 0;
    repeat (3) @(negedge clk);
    #1 chk("to_rd.waiting", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1 chk("to_rd.rsp", {rsp_valid, rsp_err}, 32'b11);
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;

    // Response held while rsp_ready low, then reset dropped mid-WAIT_RD
    @(negedge clk);
    opc = LHU; addr = 32'h106; req_valid = 1;
    @(negedge clk); req_valid = 0; mem_gnt = 1;
    @(negedge clk); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h11223344;
    @(negedge clk); mem_rvalid = 0; mem_rdata = 32'h0;
    held = 32'h00001122;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d.valid", i), 32'({rsp_valid, rsp_err}), 32'b10);
      chk($sformatf("hold%0d.rdata", i), rsp_rdata, held);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    opc = LW; addr = 32'h108; req_valid = 1;
    @(negedge clk); req_valid = 0; mem_gnt = 1;
    @(negedge clk); mem_gnt = 0; rst = 1;
    @(negedge clk); rst = 0;
    #1;
    chk("rst_rd.state", {req_ready, rsp_valid, mem_req}, 32'b100);
    mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk); mem_rvalid = 0; mem_rdata = 0;
    #1 chk("stray_rvalid", {req_ready, rsp_valid}, 32'b10);

    // Normal operation resumes
    run_vec(vecs[1], 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
